avalon_rx_bridge: RTL and testbench

Receive-side counterpart of the Avalon-ST TX path. Accepts TLP beats from the PCIe hard core's Avalon-ST RX port and buffers them in a small register FIFO. Backpressure honours the core's ready-latency contract. Beats are presented on the TRN RX interface consumed by the AXI enhanced RX block. Single clock domain: trn_clk.

---
 rtl/avalon_rx_bridge.sv | 142 ++++++++++++++
 tb/tb_avalon_rx_bridge.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/avalon_rx_bridge.sv
// avalon_rx_bridge: Avalon-ST RX (PCIe hard core) to TRN RX bridge.
// Beats from the core go into a small register FIFO, and the FIFO head drives
// the TRN RX interface. rx_st_ready0 is registered and deasserts early enough
// to absorb the beats the core may still send within its ready latency.
// Optional feature macro: AVRX_FRAME_CHECK_EN (write-side framing checker).
//
// Handshake semantics:
//   Avalon side - a beat is offered whenever rx_st_valid0=1, and it is taken
//     without looking at the current rx_st_ready0, because the core may still
//     send beats for READY_LATENCY cycles after ready falls. A beat that
//     arrives while the FIFO is full is dropped and sets overflow_err.
//   TRN side - a beat transfers on every edge where trn_rsrc_rdy & trn_rdst_rdy.
//     The head beat and trn_rsrc_rdy stay stable until they transfer.
module avalon_rx_bridge #(
    parameter int AXI_DATA_WIDTH = 128,
    parameter int BAR_WIDTH      = 8,
    parameter int FIFO_DEPTH     = 16,
    parameter int READY_LATENCY  = 2
) (
    input  logic                      trn_clk,
    input  logic                      trn_rst,
    input  logic [AXI_DATA_WIDTH-1:0] rx_st_data0,
    input  logic                      rx_st_sop0,
    input  logic                      rx_st_eop0,
    input  logic                      rx_st_empty0,
    input  logic                      rx_st_err0,
    input  logic [BAR_WIDTH-1:0]      rx_st_bardec0,
    input  logic                      rx_st_valid0,
    output logic                      rx_st_ready0,
    output logic [AXI_DATA_WIDTH-1:0] trn_rd,
    output logic                      trn_rsof,
    output logic                      trn_reof,
    output logic                      trn_rrem,
    output logic                      trn_rerrfwd,
    output logic [BAR_WIDTH-1:0]      trn_rbar_hit,
    output logic                      trn_rsrc_rdy,
    input  logic                      trn_rdst_rdy,
    output logic                      overflow_err,
    output logic [7:0]                frame_err_cnt
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam int EW = AXI_DATA_WIDTH + 4 + BAR_WIDTH;
    localparam logic [CW-1:0] DEPTH_C      = CW'(FIFO_DEPTH);
    // Largest fill level at which the core may keep streaming; leaves room
    // for READY_LATENCY+1 more beats after ready falls.
    localparam logic [CW-1:0] READY_THRESH = CW'(FIFO_DEPTH - READY_LATENCY - 2);

    logic [EW-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic [CW-1:0] count_next;
    logic          full;
    logic          push;
    logic          pop;
    logic          frame_drop;
    logic [EW-1:0] head;
    logic          head_empty;

`ifdef AVRX_FRAME_CHECK_EN
    // Packet state only matters to the framing checker.
    logic       in_pkt;
    logic       frame_err;
    logic [7:0] err_cnt;

    // Orphan continuation beats are discarded; a sop inside an open packet
    // is kept as the start of a new packet. Both count as framing errors.
    assign frame_drop = rx_st_valid0 & ~rx_st_sop0 & ~in_pkt;
    assign frame_err  = rx_st_valid0 & ((~rx_st_sop0 & ~in_pkt) | (rx_st_sop0 & in_pkt));

    // Track open packet on written beats: sop without eop opens, eop closes.
    always_ff @(posedge trn_clk) begin
        if (trn_rst) begin
            in_pkt <= 1'b0;
        end else if (push) begin
            if (rx_st_eop0)
                in_pkt <= 1'b0;
            else if (rx_st_sop0)
                in_pkt <= 1'b1;
        end
    end

    // Saturating framing error counter.
    always_ff @(posedge trn_clk) begin
        if (trn_rst)
            err_cnt <= 8'd0;
        else if (frame_err && err_cnt != 8'hFF)
            err_cnt <= err_cnt + 8'd1;
    end

    assign frame_err_cnt = err_cnt;
`else
    assign frame_drop    = 1'b0;
    assign frame_err_cnt = 8'd0;
`endif

    assign full       = (count == DEPTH_C);
    assign push       = rx_st_valid0 & ~full & ~frame_drop;
    assign trn_rsrc_rdy = (count != '0);
    assign pop        = trn_rsrc_rdy & trn_rdst_rdy;
    assign count_next = count + CW'(push) - CW'(pop);

    // Store the accepted beat at the write pointer; contents need no reset.
    always_ff @(posedge trn_clk) begin
        if (push)
            mem[wr_ptr] <= {rx_st_data0, rx_st_sop0, rx_st_eop0, rx_st_empty0,
                            rx_st_err0, rx_st_bardec0};
    end

    // Pointers, fill count and registered ready; reset drops everything buffered.
    always_ff @(posedge trn_clk) begin
        if (trn_rst) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            count        <= '0;
            rx_st_ready0 <= 1'b0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + AW'(1);
            if (pop)
                rd_ptr <= rd_ptr + AW'(1);
            count        <= count_next;
            rx_st_ready0 <= (count_next <= READY_THRESH);
        end
    end

    // Sticky overflow flag: a beat arrived with no room left.
    always_ff @(posedge trn_clk) begin
        if (trn_rst)
            overflow_err <= 1'b0;
        else if (rx_st_valid0 && full)
            overflow_err <= 1'b1;
    end

    // TRN outputs come straight from the head entry.
    assign head = mem[rd_ptr];
    assign {trn_rd, trn_rsof, trn_reof, head_empty, trn_rerrfwd, trn_rbar_hit} = head;
    assign trn_rrem = ~head_empty;

endmodule

// File: tb/tb_avalon_rx_bridge.sv
// tb_avalon_rx_bridge: directed scoreboard bench for avalon_rx_bridge.
// Drivers push expected TRN beats into exp_q; a monitor pops and compares on
// every TRN transfer.
module tb_avalon_rx_bridge;

    localparam int DW = 128;
    localparam int BW = 8;
    localparam int EW = DW + 4 + BW;

    logic          trn_clk;
    logic          trn_rst;
    logic [DW-1:0] rx_st_data0;
    logic          rx_st_sop0;
    logic          rx_st_eop0;
    logic          rx_st_empty0;
    logic          rx_st_err0;
    logic [BW-1:0] rx_st_bardec0;
    logic          rx_st_valid0;
    logic          rx_st_ready0;
    logic [DW-1:0] trn_rd;
    logic          trn_rsof;
    logic          trn_reof;
    logic          trn_rrem;
    logic          trn_rerrfwd;
    logic [BW-1:0] trn_rbar_hit;
    logic          trn_rsrc_rdy;
    logic          trn_rdst_rdy;
    logic          overflow_err;
    logic [7:0]    frame_err_cnt;

    logic [EW-1:0] exp_q[$];
    int            n_checks = 0;
    int            n_fail   = 0;

    avalon_rx_bridge dut (
        .trn_clk       (trn_clk),
        .trn_rst       (trn_rst),
        .rx_st_data0   (rx_st_data0),
        .rx_st_sop0    (rx_st_sop0),
        .rx_st_eop0    (rx_st_eop0),
        .rx_st_empty0  (rx_st_empty0),
        .rx_st_err0    (rx_st_err0),
        .rx_st_bardec0 (rx_st_bardec0),
        .rx_st_valid0  (rx_st_valid0),
        .rx_st_ready0  (rx_st_ready0),
        .trn_rd        (trn_rd),
        .trn_rsof      (trn_rsof),
        .trn_reof      (trn_reof),
        .trn_rrem      (trn_rrem),
        .trn_rerrfwd   (trn_rerrfwd),
        .trn_rbar_hit  (trn_rbar_hit),
        .trn_rsrc_rdy  (trn_rsrc_rdy),
        .trn_rdst_rdy  (trn_rdst_rdy),
        .overflow_err  (overflow_err),
        .frame_err_cnt (frame_err_cnt)
    );

    // ---------------- clock / reset ----------------
    initial trn_clk = 1'b0;
    always #5 trn_clk = ~trn_clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached, exp_q size %0d", exp_q.size());
        $fatal(1, "watchdog");
    end

    // ---------------- helpers ----------------
    task automatic chk(input string nm, input logic [159:0] act, input logic [159:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, req);
        end
    endtask

    function automatic logic [DW-1:0] mk_data(input int tag);
        logic [31:0] t;
        t = 32'(tag);
        return {t ^ 32'hA5A5_0000, t ^ 32'h5A5A_0000, ~t, t};
    endfunction

    // ---------------- driver tasks ----------------
    task automatic idle();
        rx_st_valid0  = 1'b0;
        rx_st_data0   = '0;
        rx_st_sop0    = 1'b0;
        rx_st_eop0    = 1'b0;
        rx_st_empty0  = 1'b0;
        rx_st_err0    = 1'b0;
        rx_st_bardec0 = '0;
    endtask

    // Present one beat for one cycle; valid is left high so beats can stream.
    task automatic drive_beat(input int tag, input logic sop, input logic eop,
                              input logic empty, input logic err,
                              input logic [BW-1:0] bar, input bit expect_acc);
        rx_st_valid0  = 1'b1;
        rx_st_data0   = mk_data(tag);
        rx_st_sop0    = sop;
        rx_st_eop0    = eop;
        rx_st_empty0  = empty;
        rx_st_err0    = err;
        rx_st_bardec0 = bar;
        if (expect_acc)
            exp_q.push_back({mk_data(tag), sop, eop, ~empty, err, bar});
        @(posedge trn_clk); #1;
    endtask

    task automatic cycles(input int n);
        repeat (n) begin
            @(posedge trn_clk); #1;
        end
    endtask

    task automatic do_reset();
        trn_rst = 1'b1;
        idle();
        exp_q.delete();
        cycles(2);
        chk("rst_src_rdy", trn_rsrc_rdy, 0);
        chk("rst_ready", rx_st_ready0, 0);
        chk("rst_overflow", overflow_err, 0);
        chk("rst_frame_cnt", frame_err_cnt, 0);
        trn_rst = 1'b0;
        cycles(1);
        chk("rst_ready_after_release", rx_st_ready0, 1);
    endtask

    // Wait (bounded) until every expected beat has been seen, then FIFO empty.
    task automatic drain(input string nm);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 200) begin
            cycles(1);
            n++;
        end
        chk({nm, "_drained"}, 160'(exp_q.size()), 0);
        chk({nm, "_empty"}, trn_rsrc_rdy, 0);
    endtask

    // ---------------- scoreboard monitor ----------------
    always @(negedge trn_clk) begin
        if (trn_rst === 1'b0 && trn_rsrc_rdy === 1'b1 && trn_rdst_rdy === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL trn_unexpected: got beat %0h expected none",
                         {trn_rd, trn_rsof, trn_reof, trn_rrem, trn_rerrfwd, trn_rbar_hit});
            end else begin
                chk("trn_beat", {trn_rd, trn_rsof, trn_reof, trn_rrem, trn_rerrfwd, trn_rbar_hit},
                    exp_q.pop_front());
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        bit h0, h1, h2;
        int accepted;
        trn_rst      = 1'b1;
        trn_rdst_rdy = 1'b1;
        idle();

        // T1: reset, 3-beat TLP, first beat visible the cycle after its write
        do_reset();
        drive_beat(1, 1'b1, 1'b0, 1'b0, 1'b0, 8'h01, 1'b1);
        chk("t1_latency_src_rdy", trn_rsrc_rdy, 1);
        chk("t1_latency_sof", trn_rsof, 1);
        chk("t1_latency_bar", trn_rbar_hit, 8'h01);
        drive_beat(2, 1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 1'b1);
        drive_beat(3, 1'b0, 1'b1, 1'b1, 1'b0, 8'h00, 1'b1);
        idle();
        drain("t1");

        // T4: 20 back-to-back single-beat TLPs at full rate
        for (int i = 0; i < 20; i++) begin
            drive_beat(40 + i, 1'b1, 1'b1, i[0], 1'b0, 8'(i), 1'b1);
            chk("t4_src_rdy_cont", trn_rsrc_rdy, 1);
            chk("t4_ready_held", rx_st_ready0, 1);
        end
        idle();
        drain("t4");
        cycles(3);

        // T2: downstream stalled, core honours ready latency of 2 cycles
        trn_rdst_rdy = 1'b0;
        h0 = 1'b1; h1 = 1'b1; h2 = 1'b1;
        accepted = 0;
        for (int j = 0; j < 20; j++) begin
            h2 = h1;
            h1 = h0;
            h0 = rx_st_ready0;
            if (h2) begin
                drive_beat(100 + j, (j == 0), 1'b0, 1'b0, 1'b0, (j == 0) ? 8'h02 : 8'h00, 1'b1);
                accepted++;
            end else begin
                idle();
                cycles(1);
            end
        end
        idle();
        chk("t2_accepted", 160'(accepted), 15);
        chk("t2_ready_low", rx_st_ready0, 0);
        chk("t2_no_overflow", overflow_err, 0);

        // T3: fill the last slot, then push into a full FIFO
        drive_beat(200, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
        idle();
        chk("t3_16th_no_overflow", overflow_err, 0);
        drive_beat(201, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
        idle();
        chk("t3_overflow_set", overflow_err, 1);
        trn_rdst_rdy = 1'b1;
        drain("t3");
        chk("t3_overflow_sticky", overflow_err, 1);
        do_reset();

        // T5: reset after 2 of 4 beats drops them; a clean TLP follows
        trn_rdst_rdy = 1'b0;
        drive_beat(300, 1'b1, 1'b0, 1'b0, 1'b0, 8'h08, 1'b0);
        drive_beat(301, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
        idle();
        trn_rst = 1'b1;
        cycles(1);
        chk("t5_flush_src_rdy", trn_rsrc_rdy, 0);
        do_reset();
        trn_rdst_rdy = 1'b1;
        drive_beat(310, 1'b1, 1'b0, 1'b0, 1'b0, 8'h20, 1'b1);
        drive_beat(311, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
        drive_beat(312, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
        drive_beat(313, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b1);
        idle();
        drain("t5");

        // T6: orphan continuation beat, then sop inside an open packet
`ifdef AVRX_FRAME_CHECK_EN
        drive_beat(400, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
`else
        drive_beat(400, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
`endif
        drive_beat(401, 1'b1, 1'b0, 1'b0, 1'b0, 8'h04, 1'b1);
        drive_beat(402, 1'b1, 1'b0, 1'b0, 1'b0, 8'h10, 1'b1);
        drive_beat(403, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b1);
        idle();
        drain("t6");
`ifdef AVRX_FRAME_CHECK_EN
        chk("t6_frame_err_cnt", frame_err_cnt, 2);
`else
        chk("t6_frame_err_cnt", frame_err_cnt, 0);
`endif

        // ---------------- report ----------------
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
